// File: rtl/board_lock.sv
// Locks the falling 4x4 piece into the 10x20 static board, then collapses full rows
// bottom-up, one row evaluation per clock, before publishing the new board.
module board_lock #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   start,
  input  logic [3:0]             pos_x,
  input  logic [4:0]             pos_y,
  input  logic [0:15]            float,
  input  logic [0:COLS*ROWS-1]   static_in,
  output logic [0:COLS*ROWS-1]   static_out,
  output logic [2:0]             lines,
  output logic                   overflow,
  output logic                   collision,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [0:COLS*ROWS-1]    work_q, work_d;
  logic [0:COLS*ROWS-1]    out_q, out_d;
  logic [4:0]              r_q, r_d;
  logic [2:0]              lines_q, lines_d;
  logic                    ovf_q, ovf_d;
  logic                    col_q, col_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [0:COLS*ROWS-1]    mask_s;
  logic                    ovf_s;
  logic                    col_s;
  logic [0:COLS*ROWS-1]    shifted_s;
  logic                    row_full_s;

  // Project the piece onto the board: off-board cells vanish, rows 20..22 flag overflow.
  always_comb begin
    logic [5:0] row_v;
    logic [4:0] colv;
    logic       keep_v;
    logic       in_board_v;
    int         idx;
    mask_s = '0;
    ovf_s  = 1'b0;
    col_s  = 1'b0;
    for (int dr = 0; dr < 4; dr++) begin
      for (int dc = 0; dc < 4; dc++) begin
        row_v      = {1'b0, pos_y} - 6'(dr);
        colv       = {1'b0, pos_x} - 5'(dc);
        keep_v     = float[(3 - dr) * 4 + (3 - dc)] && !row_v[5] && !colv[4] && (colv < 5'(COLS));
        in_board_v = keep_v && (row_v < 6'(ROWS));
        ovf_s      = ovf_s | (keep_v && (row_v >= 6'(ROWS)) && (row_v <= 6'd22));
        idx        = in_board_v ? (int'(row_v) * COLS + int'(colv)) : 0;
        mask_s[idx] = mask_s[idx] | in_board_v;
        col_s      = col_s | (in_board_v & static_in[idx]);
      end
    end
  end

  // Collapse row r: rows above drop by one, the top row fills with zeros.
  always_comb begin
    row_full_s = &work_q[int'(r_q) * COLS +: COLS];
    shifted_s  = '0;
    for (int i = 0; i < ROWS - 1; i++) begin
      shifted_s[i * COLS +: COLS] = (5'(i) < r_q) ? work_q[i * COLS +: COLS]
                                                  : work_q[(i + 1) * COLS +: COLS];
    end
    shifted_s[(ROWS - 1) * COLS +: COLS] = '0;
  end

  // Next-state logic for the lock/scan sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    r_d     = r_q;
    lines_d = lines_q;
    ovf_d   = ovf_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = static_in | mask_s;
          r_d     = 5'd0;
          lines_d = 3'd0;
          ovf_d   = ovf_s;
          col_d   = col_s;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (row_full_s) begin
          work_d  = shifted_s;
          lines_d = (lines_q == 3'd7) ? 3'd7 : lines_q + 3'd1;
        end else if (r_q < 5'(ROWS - 1)) begin
          r_d = r_q + 5'd1;
        end else begin
          out_d   = work_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      r_q     <= 5'd0;
      lines_q <= 3'd0;
      ovf_q   <= 1'b0;
      col_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      r_q     <= r_d;
      lines_q <= lines_d;
      ovf_q   <= ovf_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign static_out = out_q;
  assign lines      = lines_q;
  assign overflow   = ovf_q;
  assign collision  = col_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
